add_round_key_stage: RTL and testbench

//  Downstream neighbour of the MixColumns stage: XORs each incoming 128-bit AES state

---
 rtl/add_round_key_stage.sv | 161 ++++++++++++++++
 tb/tb_add_round_key_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stage.sv
// -----------------------------------------------------------------------------
// add_round_key_stage
//
// AES AddRoundKey pipeline stage. Each accepted 128-bit state is XORed with the
// round key selected by a locally tracked round counter, and the result is
// registered. All NR+1 round keys live in a local key store that is written
// through a simple indexed write port. A 2-entry (output register + one skid
// slot) buffer keeps full throughput under backpressure.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   key_we     round-key write strobe
//   key_waddr  round-key index (writes with index > NR are ignored)
//   key_wdata  round-key value, bit 127 = byte 0
//   in_valid   in_data / in_first valid
//   in_ready   stage can accept this cycle
//   in_data    state from MixColumns (or plaintext for round 0)
//   in_first   beat is round 0 of a new block
//   out_valid  out_* valid
//   out_ready  consumer accepts this cycle
//   out_data   in_data ^ key[round]
//   out_round  round index used for this beat
//   out_last   out_round == NR
//
// Skid occupancy (skid_valid):
//   state | meaning
//   ------+--------------------------------------------------------------
//   empty | output register absorbs the next beat, in_ready follows !rst
//   full  | one beat parked behind a stalled output, in_ready low
// -----------------------------------------------------------------------------

module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         key_we,
    input  logic [3:0]   key_waddr,
    input  logic [127:0] key_wdata,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_first,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [127:0] key_mem [0:NR];

    logic [3:0]   rnd;
    logic [3:0]   r_sel;
    logic [3:0]   rnd_nxt;

    logic         acc;
    logic         out_load;

    logic [127:0] beat_data;
    logic         beat_last;

    logic         skid_valid;
    logic [127:0] skid_data;
    logic [3:0]   skid_round;
    logic         skid_last;

    // -------------------------------------------------------------------------
    // Handshake and beat formation
    // -------------------------------------------------------------------------

    // The skid slot is the only place a second beat can wait, so refusing input
    // while it is occupied guarantees nothing is ever overwritten.
    assign in_ready = !skid_valid && !rst;
    assign acc      = in_valid && in_ready;

    // in_first forces round 0 regardless of where the counter is, so a block
    // that was abandoned mid-way simply restarts.
    assign r_sel     = in_first ? 4'd0 : rnd;
    assign rnd_nxt   = (r_sel == LAST_RND) ? 4'd0 : r_sel + 4'd1;
    assign beat_last = (r_sel == LAST_RND);

    // Key store read is combinational from the registered array, so a key
    // write on the accept edge is only seen by later beats.
    assign beat_data = in_data ^ key_mem[r_sel];

    // Output register may take a new value when empty or being drained.
    assign out_load = !out_valid || out_ready;

    // -------------------------------------------------------------------------
    // Key store
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                key_mem[i] <= '0;
            end
        end else if (key_we && (key_waddr <= LAST_RND)) begin
            key_mem[key_waddr] <= key_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Round counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd <= 4'd0;
        end else if (acc) begin
            rnd <= rnd_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Output register and skid slot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_round  <= 4'd0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_round <= 4'd0;
            skid_last  <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                // Oldest beat first. in_ready was low this cycle, so there is
                // no accepted beat competing for the slot.
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_round  <= skid_round;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
            end else if (acc) begin
                out_valid  <= 1'b1;
                out_data   <= beat_data;
                out_round  <= r_sel;
                out_last   <= beat_last;
            end else begin
                // Data fields are left as they were; only valid drops.
                out_valid  <= 1'b0;
            end
        end else if (acc) begin
            // Output stalled: park the new beat. Only reachable with the slot
            // empty because acc implies in_ready.
            skid_valid <= 1'b1;
            skid_data  <= beat_data;
            skid_round <= r_sel;
            skid_last  <= beat_last;
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
module tb_add_round_key_stage;

    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic         key_we;
    logic [3:0]   key_waddr;
    logic [127:0] key_wdata;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;

    add_round_key_stage #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_waddr (key_waddr),
        .key_wdata (key_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_round (out_round),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
    } beat_t;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] ks   [0:NR];
    logic [127:0] mkey [0:NR];
    int           mrnd;
    beat_t        exp_q [$];

    logic [127:0] pt;
    logic [127:0] ct0;
    logic [127:0] new_key;
    int           k;
    bit           adv;
    bit           ordy [8];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int n);
        logic [31:0] w;
        w = 32'(n);
        return {w * 32'h01010101, 32'hcafef00d ^ w, 32'h12345678 + w, ~w};
    endfunction

    // One clock: score the beat leaving, model the beat entering, then step.
    task automatic tick();
        beat_t b;
        int    r;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 128'(out_valid), 128'(0));
            end else begin
                b = exp_q.pop_front();
                chk("sb_data",  out_data,          b.d);
                chk("sb_round", 128'(out_round),   128'(b.r));
                chk("sb_last",  128'(out_last),    128'(b.l));
            end
        end
        if (rst) begin
            exp_q.delete();
            mrnd = 0;
            for (int i = 0; i <= NR; i++) mkey[i] = '0;
        end else begin
            if (in_valid && in_ready) begin
                r   = in_first ? 0 : mrnd;
                b.d = in_data ^ mkey[r];
                b.r = 4'(r);
                b.l = (r == NR);
                exp_q.push_back(b);
                mrnd = (r == NR) ? 0 : r + 1;
            end
            if (key_we && int'(key_waddr) <= NR) mkey[key_waddr] = key_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ks[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ks[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        pt      = 128'h3243f6a8885a308d313198a2e0370734;
        ct0     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        new_key = 128'h00112233445566778899aabbccddeeff;
        mrnd    = 0;

        rst = 1'b1; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
        in_valid = 1'b0; in_data = '0; in_first = 1'b0; out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  128'(in_ready),  128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data",  out_data,        128'(0));
        chk("rst_out_round", 128'(out_round), 128'(0));
        chk("rst_out_last",  128'(out_last),  128'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'(1));

        // Load FIPS-197 App. B key schedule
        for (int i = 0; i <= NR; i++) begin
            key_we = 1'b1; key_waddr = 4'(i); key_wdata = ks[i];
            tick();
        end
        key_we = 1'b0;

        // 1: round 0 of App. B
        out_ready = 1'b1;
        in_valid = 1'b1; in_first = 1'b1; in_data = pt;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_data",  out_data,        ct0);
        chk("t1_round", 128'(out_round), 128'(0));
        chk("t1_last",  128'(out_last),  128'(0));
        tick();

        // 2: 11 rounds then wrap to round 0
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_first = (i == 0); in_data = mk(i);
            tick();
            chk("t2_valid", 128'(out_valid), 128'(1));
            chk("t2_round", 128'(out_round), 128'((i == 11) ? 0 : i));
            chk("t2_last",  128'(out_last),  128'(i == 10));
        end
        in_valid = 1'b0; in_first = 1'b0;
        tick();
        chk("t2_drained", 128'(out_valid), 128'(0));

        // 3: three stalled cycles during streaming
        k = 0;
        ordy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            out_ready = ordy[c];
            in_valid  = (k < 5);
            in_first  = (k == 0);
            in_data   = mk(100 + k);
            adv = in_valid && in_ready;
            tick();
            if (adv) k++;
            chk("t3_valid", 128'(out_valid), 128'(1));
            case (c)
                0: chk("t3_ready_one_held", 128'(in_ready), 128'(1));
                1: chk("t3_ready_two_held", 128'(in_ready), 128'(0));
                3: begin
                    chk("t3_ready_stall", 128'(in_ready),  128'(0));
                    chk("t3_hold_round",  128'(out_round), 128'(0));
                    chk("t3_hold_data",   out_data,        mk(100) ^ ks[0]);
                end
                4: begin
                    chk("t3_release_round", 128'(out_round), 128'(1));
                    chk("t3_release_ready", 128'(in_ready),  128'(1));
                end
                5: chk("t3_round2", 128'(out_round), 128'(2));
                6: chk("t3_round3", 128'(out_round), 128'(3));
                7: chk("t3_round4", 128'(out_round), 128'(4));
                default: ;
            endcase
        end
        in_valid = 1'b0; in_first = 1'b0;
        tick();
        chk("t3_count", 128'(k), 128'(5));

        // 4: key write colliding with a round-5 accept, then an ignored index
        in_valid = 1'b1; in_first = 1'b0; in_data = mk(200);
        key_we = 1'b1; key_waddr = 4'd5; key_wdata = new_key;
        tick();
        key_we = 1'b0;
        chk("t4_old_round", 128'(out_round), 128'(5));
        chk("t4_old_key",   out_data,        mk(200) ^ ks[5]);
        in_valid = 1'b0;
        key_we = 1'b1; key_waddr = 4'd11; key_wdata = '1;
        tick();
        key_we = 1'b0;
        for (int i = 0; i <= NR; i++) begin
            in_valid = 1'b1; in_first = (i == 0); in_data = mk(300 + i);
            tick();
            chk("t4_round", 128'(out_round), 128'(i));
            if (i == 5)  chk("t4_new_key",  out_data, mk(305) ^ new_key);
            if (i == 0)  chk("t4_key0",     out_data, mk(300) ^ ks[0]);
            if (i == 10) chk("t4_key10",    out_data, mk(310) ^ ks[10]);
        end
        in_valid = 1'b0; in_first = 1'b0;
        tick();

        // 6: in_first mid-sequence restarts at round 0
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_first = (i == 0); in_data = mk(350 + i);
            tick();
        end
        in_valid = 1'b1; in_first = 1'b1; in_data = mk(400);
        tick();
        chk("t6_restart_round", 128'(out_round), 128'(0));
        chk("t6_restart_data",  out_data,        mk(400) ^ ks[0]);
        in_first = 1'b0; in_data = mk(401);
        tick();
        chk("t6_next_round", 128'(out_round), 128'(1));
        chk("t6_next_data",  out_data,        mk(401) ^ ks[1]);
        in_valid = 1'b0;
        tick();

        // 5: reset mid-stream with a stalled output
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b0; in_data = mk(500);
        tick();
        in_data = mk(501);
        tick();
        chk("t5_pre_valid", 128'(out_valid), 128'(1));
        rst = 1'b1;
        tick();
        chk("t5_rst_valid", 128'(out_valid), 128'(0));
        chk("t5_rst_data",  out_data,        128'(0));
        chk("t5_rst_ready", 128'(in_ready),  128'(0));
        rst = 1'b0;
        #1;
        chk("t5_ready_after", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        in_valid = 1'b1; in_first = 1'b0; in_data = mk(600);
        tick();
        in_valid = 1'b0;
        chk("t5_valid", 128'(out_valid), 128'(1));
        chk("t5_round", 128'(out_round), 128'(0));
        chk("t5_data",  out_data,        mk(600));
        tick();

        chk("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
